// File: rtl/bus_pkg.sv
// Shared system-bus definitions: strobe/direction encodings, default widths
// and the arbiter state type used by bus_arbiter and bus_addr_dec.
package bus_pkg;

  localparam logic BUS_READ   = 1'b1;
  localparam logic BUS_WRITE  = 1'b0;
  localparam logic AS_ENABLE  = 1'b0;
  localparam logic AS_DISABLE = 1'b1;

  localparam int BUS_ADDR_WIDTH  = 32;
  localparam int BUS_DATA_WIDTH  = 32;
  localparam int BUS_NUM_MASTERS = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request found searching
// upward from ptr+1 (wrapping), returned one-hot with a valid flag.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // k == N wraps back to ptr itself, so ptr has lowest priority
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered, request-held grant and a
// combinational master-to-slave mux driven by the current owner.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = BUS_NUM_MASTERS,
  parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int MAX_HOLD    = 256,
  localparam int OW = $clog2(NUM_MASTERS),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  output logic [NUM_MASTERS-1:0]            m_grnt_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]            m_as_n_i,
  input  logic [NUM_MASTERS-1:0]            m_rw_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data_i,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic                              s_as_n_o,
  output logic                              s_rw_o,
  output logic [DATA_WIDTH-1:0]             s_wr_data_o,
  output logic [OW-1:0]                     bus_owner_o,
  output logic                              bus_busy_o,
  output logic                              arb_timeout_o,
  input  logic                              timeout_clr_i
);

  arb_state_t             state_reg;
  logic [NUM_MASTERS-1:0] grant_reg;
  logic [OW-1:0]          ptr_reg;
  logic [OW-1:0]          owner_reg;
  logic                   busy_reg;
  logic [HW-1:0]          hold_reg;
  logic                   timeout_reg;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic                   pick_valid;
  logic [OW-1:0]          pick_idx;
  logic                   owner_req;
  logic                   others_waiting;

  // The pointer always equals the current owner while OWNED, so the same
  // selector serves both the idle pick and the zero-bubble handover.
  rr_pick #(
    .N  (NUM_MASTERS),
    .PW (OW)
  ) u_rr_pick (
    .req   (m_req_i),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_grant[i]) pick_idx = pick_idx | OW'(i);
    end
  end

  assign owner_req      = m_req_i[owner_reg];
  assign others_waiting = |(m_req_i & ~grant_reg);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= ARB_IDLE;
      grant_reg   <= '0;
      ptr_reg     <= OW'(NUM_MASTERS - 1);
      owner_reg   <= '0;
      busy_reg    <= 1'b0;
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      // A set further down overrides this clear in the same cycle.
      if (timeout_clr_i) timeout_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          hold_reg <= '0;
          if (pick_valid) begin
            grant_reg <= pick_grant;
            owner_reg <= pick_idx;
            ptr_reg   <= pick_idx;
            busy_reg  <= 1'b1;
            state_reg <= ARB_OWNED;
          end
        end
        ARB_OWNED: begin
          if (owner_req) begin
            if (others_waiting && hold_reg != HW'(MAX_HOLD)) begin
              hold_reg <= hold_reg + 1'b1;
              if (hold_reg == HW'(MAX_HOLD - 1)) timeout_reg <= 1'b1;
            end
          end else if (pick_valid) begin
            grant_reg <= pick_grant;
            owner_reg <= pick_idx;
            ptr_reg   <= pick_idx;
            hold_reg  <= '0;
          end else begin
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            hold_reg  <= '0;
            state_reg <= ARB_IDLE;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    s_addr_o    = '0;
    s_as_n_o    = AS_DISABLE;
    s_rw_o      = BUS_READ;
    s_wr_data_o = '0;
    if (busy_reg) begin
      s_addr_o    = m_addr_i[owner_reg*ADDR_WIDTH +: ADDR_WIDTH];
      s_as_n_o    = m_as_n_i[owner_reg];
      s_rw_o      = m_rw_i[owner_reg];
      s_wr_data_o = m_wr_data_i[owner_reg*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign m_grnt_o      = grant_reg;
  assign bus_owner_o   = owner_reg;
  assign bus_busy_o    = busy_reg;
  assign arb_timeout_o = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboarded directed test of bus_arbiter: stimulus queues hand-computed
// expectations per cycle, a monitor compares them at the falling edge.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 8;
  localparam int OW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_grnt;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]    m_as_n;
  logic [N-1:0]    m_rw;
  logic [N*DW-1:0] m_wr_data;
  logic [AW-1:0]   s_addr;
  logic            s_as_n;
  logic            s_rw;
  logic [DW-1:0]   s_wr_data;
  logic [OW-1:0]   bus_owner;
  logic            bus_busy;
  logic            arb_timeout;
  logic            timeout_clr;

  logic [AW-1:0] addr_tab [N];
  logic [DW-1:0] data_tab [N];

  typedef struct {
    logic [N-1:0] grant;
    logic         to;
    logic [N-1:0] req;
    string        tag;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MAX_HOLD    (MH)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .m_req_i       (m_req),
    .m_grnt_o      (m_grnt),
    .m_addr_i      (m_addr),
    .m_as_n_i      (m_as_n),
    .m_rw_i        (m_rw),
    .m_wr_data_i   (m_wr_data),
    .s_addr_o      (s_addr),
    .s_as_n_o      (s_as_n),
    .s_rw_o        (s_rw),
    .s_wr_data_o   (s_wr_data),
    .bus_owner_o   (bus_owner),
    .bus_busy_o    (bus_busy),
    .arb_timeout_o (arb_timeout),
    .timeout_clr_i (timeout_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs after the edge, queue what the DUT
  // should show during this same cycle.
  task automatic cyc(input logic [N-1:0] req, input logic clr,
                     input logic [N-1:0] eg, input logic eto, input string tag);
    @(posedge clk);
    #1;
    m_req       = req;
    m_as_n      = ~req;
    timeout_clr = clr;
    sb_q.push_back('{grant: eg, to: eto, req: req, tag: tag});
  endtask

  // Monitor
  initial begin
    exp_t          e;
    int            o;
    logic          busy;
    logic [AW-1:0] ea;
    logic          eas;
    logic          erw;
    logic [DW-1:0] ed;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e    = sb_q.pop_front();
        busy = |e.grant;
        o    = 0;
        for (int i = 0; i < N; i++) if (e.grant[i]) o = i;
        ea  = busy ? addr_tab[o] : '0;
        eas = busy ? ~e.req[o] : 1'b1;
        erw = busy ? m_rw[o] : 1'b1;
        ed  = busy ? data_tab[o] : '0;
        check({e.tag, " grant"}, 64'(m_grnt), 64'(e.grant));
        check({e.tag, " busy"}, 64'(bus_busy), 64'(busy));
        if (busy) check({e.tag, " owner"}, 64'(bus_owner), 64'(o));
        check({e.tag, " s_addr"}, 64'(s_addr), 64'(ea));
        check({e.tag, " s_as_n"}, 64'(s_as_n), 64'(eas));
        check({e.tag, " s_rw"}, 64'(s_rw), 64'(erw));
        check({e.tag, " s_wr_data"}, 64'(s_wr_data), 64'(ed));
        check({e.tag, " timeout"}, 64'(arb_timeout), 64'(e.to));
        $display("cycle %s: req=%b grant=%b owner=%0d addr=%h to=%b",
                 e.tag, e.req, m_grnt, bus_owner, s_addr, arb_timeout);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_tab[0] = 32'h1000_0000;
    addr_tab[1] = 32'h2000_0004;
    addr_tab[2] = 32'h4000_0010;
    addr_tab[3] = 32'h8000_000C;
    for (int i = 0; i < N; i++) begin
      data_tab[i] = 32'hDA7A_0000 + 32'(i);
      m_addr[i*AW +: AW]    = addr_tab[i];
      m_wr_data[i*DW +: DW] = data_tab[i];
      m_rw[i]               = i[0];
    end
    rst_n       = 1'b0;
    m_req       = '0;
    m_as_n      = '1;
    timeout_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset grant", 64'(m_grnt), 64'h0);
    check("reset busy", 64'(bus_busy), 64'h0);
    check("reset owner", 64'(bus_owner), 64'h0);
    check("reset timeout", 64'(arb_timeout), 64'h0);
    check("reset s_addr", 64'(s_addr), 64'h0);
    check("reset s_as_n", 64'(s_as_n), 64'h1);
    check("reset s_rw", 64'(s_rw), 64'h1);
    check("reset s_wr_data", 64'(s_wr_data), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request from master 2, then release with nothing pending
    cyc(4'b0000, 0, 4'b0000, 0, "a0");
    cyc(4'b0100, 0, 4'b0000, 0, "a1");
    cyc(4'b0100, 0, 4'b0100, 0, "a2");
    cyc(4'b0000, 0, 4'b0100, 0, "a3");
    cyc(4'b0000, 0, 4'b0000, 0, "a4");

    // Master 1 owns; master 3 pulses one cycle and must never be granted
    cyc(4'b0010, 0, 4'b0000, 0, "d0");
    cyc(4'b1010, 0, 4'b0010, 0, "d1");
    cyc(4'b0010, 0, 4'b0010, 0, "d2");
    cyc(4'b0000, 0, 4'b0010, 0, "d3");
    cyc(4'b0000, 0, 4'b0000, 0, "d4");

    // Master 0 holds while master 3 waits: timeout after 8 waiting cycles
    cyc(4'b0001, 0, 4'b0000, 0, "e0");
    for (int k = 1; k <= 8; k++) cyc(4'b1001, 0, 4'b0001, 0, $sformatf("e%0d", k));
    cyc(4'b1000, 0, 4'b0001, 1, "e9");
    cyc(4'b1000, 0, 4'b1000, 1, "e10");
    cyc(4'b0000, 0, 4'b1000, 1, "e11");
    cyc(4'b0000, 0, 4'b0000, 1, "e12");
    cyc(4'b0000, 1, 4'b0000, 1, "e13");
    cyc(4'b0000, 0, 4'b0000, 0, "e14");

    // Asynchronous reset while master 2 owns
    cyc(4'b0100, 0, 4'b0000, 0, "f0");
    cyc(4'b0100, 0, 4'b0100, 0, "f1");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset grant", 64'(m_grnt), 64'h0);
    check("async reset busy", 64'(bus_busy), 64'h0);
    check("async reset s_as_n", 64'(s_as_n), 64'h1);
    m_req  = 4'b0101;
    m_as_n = ~m_req;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // After release master 0 wins, then strict rotation with all requesting
    cyc(4'b0101, 0, 4'b0001, 0, "g0");
    cyc(4'b1111, 0, 4'b0001, 0, "g1");
    cyc(4'b1111, 0, 4'b0001, 0, "g2");
    cyc(4'b1110, 0, 4'b0001, 0, "g3");
    cyc(4'b1111, 0, 4'b0010, 0, "g4");
    cyc(4'b1111, 0, 4'b0010, 0, "g5");
    cyc(4'b1101, 0, 4'b0010, 0, "g6");
    cyc(4'b1111, 0, 4'b0100, 0, "g7");
    cyc(4'b1111, 0, 4'b0100, 0, "g8");
    cyc(4'b1011, 0, 4'b0100, 0, "g9");
    cyc(4'b1111, 0, 4'b1000, 0, "g10");
    cyc(4'b1111, 0, 4'b1000, 0, "g11");
    cyc(4'b0111, 0, 4'b1000, 0, "g12");
    cyc(4'b0000, 0, 4'b0001, 0, "g13");
    cyc(4'b0000, 0, 4'b0000, 0, "g14");

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
